// File: rtl/dpr_pkg.sv
// dpr_pkg -- shared types and constants for the multi-lane weight memory.
//   rd_state_t : burst read sequencer states
//   DPR_*      : default geometry (lanes, element width, depth, address widths)
//   lane_lsb() : bit offset of a lane's element inside a packed row
package dpr_pkg;

  localparam int DPR_LANES        = 4;
  localparam int DPR_ELEMENT_BITS = 8;
  localparam int DPR_RAM_DEPTH    = 27;
  localparam int DPR_ADDR_BITS    = 5;
  localparam int DPR_LANE_BITS    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_t;

  function automatic int lane_lsb(input int lane, input int element_bits);
    return lane * element_bits;
  endfunction

endpackage

// File: rtl/dpr_rd_seq.sv
// dpr_rd_seq -- burst read sequencer for dpr_bank.
// Walks rows base..base+len-1 (wrapping at RAM_DEPTH), issuing one row read
// per non-stalled cycle.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_start/i_base/i_len: burst request (accepted only in IDLE)
//   i_stall             : downstream hold, freezes the sequencer
//   o_busy              : burst in progress
//   o_rd_en/o_rd_addr   : row read issued this cycle and its address
//   o_rd_last           : the row read this cycle is the burst's final row
//   o_base_oob          : request rejected because base is past the last row
//
// state | meaning
// IDLE  | waiting for a burst request
// RUN   | issuing row reads, one per non-stalled cycle
import dpr_pkg::*;

module dpr_rd_seq #(
  parameter int RAM_DEPTH = DPR_RAM_DEPTH,
  parameter int ADDR_BITS = DPR_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [ADDR_BITS-1:0] i_base,
  input  logic [ADDR_BITS:0]   i_len,
  input  logic                 i_stall,
  output logic                 o_busy,
  output logic                 o_rd_en,
  output logic [ADDR_BITS-1:0] o_rd_addr,
  output logic                 o_rd_last,
  output logic                 o_base_oob
);

  localparam logic [ADDR_BITS:0]   DEPTH_W  = RAM_DEPTH[ADDR_BITS:0];
  localparam logic [ADDR_BITS-1:0] LAST_ROW = ADDR_BITS'(RAM_DEPTH - 1);
  localparam logic [ADDR_BITS:0]   REM_ONE  = (ADDR_BITS+1)'(1);

  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [ADDR_BITS-1:0]  w_addr_nxt;
  logic [ADDR_BITS:0]    r_rem;
  logic [ADDR_BITS:0]    w_rem_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    o_rd_en     = 1'b0;
    o_rd_last   = 1'b0;
    o_base_oob  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && (i_len != '0)) begin
          if ({1'b0, i_base} < DEPTH_W) begin
            w_state_nxt = RUN;
            w_addr_nxt  = i_base;
            w_rem_nxt   = i_len;
          end else begin
            o_base_oob = 1'b1;
          end
        end
      end
      RUN: begin
        if (!i_stall) begin
          o_rd_en    = 1'b1;
          o_rd_last  = (r_rem == REM_ONE);
          w_addr_nxt = (r_addr == LAST_ROW) ? '0 : r_addr + 1'b1;
          w_rem_nxt  = r_rem - 1'b1;
          if (r_rem == REM_ONE) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy    = (r_state == RUN);
  assign o_rd_addr = r_addr;

endmodule

// File: rtl/dpr_bank.sv
// dpr_bank -- multi-lane weight memory: LANES element columns sharing one row
// address space, element-granular writes, burst row reads to the array.
//   sys_clk, reset_n          : clock, async active-low reset (clears memory)
//   wr_cs/wr_we/wr_lane/wr_addr/wr_data : element write port
//   rd_start/rd_base/rd_len   : burst request
//   rd_stall                  : downstream hold
//   rd_busy/rd_valid/rd_last/rd_data    : burst status and registered row
//   err_oob                   : one-cycle pulse when a write or burst is
//                               dropped for being out of range
// Build option: DPR_BANK_BYPASS_EN forwards a same-cycle write into the row
// being read (write-first); without it the read returns the old element.
import dpr_pkg::*;

module dpr_bank #(
  parameter int LANES        = DPR_LANES,
  parameter int ELEMENT_BITS = DPR_ELEMENT_BITS,
  parameter int RAM_DEPTH    = DPR_RAM_DEPTH,
  parameter int ADDR_BITS    = DPR_ADDR_BITS,
  parameter int LANE_BITS    = DPR_LANE_BITS
) (
  input  logic                          sys_clk,
  input  logic                          reset_n,
  input  logic                          wr_cs,
  input  logic                          wr_we,
  input  logic [LANE_BITS-1:0]          wr_lane,
  input  logic [ADDR_BITS-1:0]          wr_addr,
  input  logic [ELEMENT_BITS-1:0]       wr_data,
  input  logic                          rd_start,
  input  logic [ADDR_BITS-1:0]          rd_base,
  input  logic [ADDR_BITS:0]            rd_len,
  input  logic                          rd_stall,
  output logic                          rd_busy,
  output logic                          rd_valid,
  output logic                          rd_last,
  output logic [LANES*ELEMENT_BITS-1:0] rd_data,
  output logic                          err_oob
);

  localparam logic [ADDR_BITS:0] DEPTH_W = RAM_DEPTH[ADDR_BITS:0];
  localparam logic [LANE_BITS:0] LANES_W = LANES[LANE_BITS:0];

  logic [ELEMENT_BITS-1:0]       r_mem [LANES][RAM_DEPTH];
  logic                          r_rd_valid;
  logic                          r_rd_last;
  logic [LANES*ELEMENT_BITS-1:0] r_rd_data;
  logic                          r_err_oob;

  logic                          w_wr_req;
  logic                          w_wr_ok;
  logic                          w_wr_oob;
  logic                          w_rd_en;
  logic [ADDR_BITS-1:0]          w_rd_addr;
  logic                          w_rd_last;
  logic                          w_base_oob;
  logic [LANES*ELEMENT_BITS-1:0] w_row_data;

  assign w_wr_req = wr_cs && wr_we;
  assign w_wr_ok  = w_wr_req && ({1'b0, wr_addr} < DEPTH_W) && ({1'b0, wr_lane} < LANES_W);
  assign w_wr_oob = w_wr_req && !w_wr_ok;

  dpr_rd_seq #(
    .RAM_DEPTH (RAM_DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_rd_seq (
    .i_clk      (sys_clk),
    .i_rst_n    (reset_n),
    .i_start    (rd_start),
    .i_base     (rd_base),
    .i_len      (rd_len),
    .i_stall    (rd_stall),
    .o_busy     (rd_busy),
    .o_rd_en    (w_rd_en),
    .o_rd_addr  (w_rd_addr),
    .o_rd_last  (w_rd_last),
    .o_base_oob (w_base_oob)
  );

  // Flop-based storage so reset can clear every element.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < LANES; k++) begin
        for (int r = 0; r < RAM_DEPTH; r++) begin
          r_mem[k][r] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      r_mem[wr_lane][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    w_row_data = '0;
    for (int k = 0; k < LANES; k++) begin
      w_row_data[lane_lsb(k, ELEMENT_BITS) +: ELEMENT_BITS] = r_mem[k][w_rd_addr];
`ifdef DPR_BANK_BYPASS_EN
      if (w_wr_ok && (wr_lane == LANE_BITS'(k)) && (wr_addr == w_rd_addr)) begin
        w_row_data[lane_lsb(k, ELEMENT_BITS) +: ELEMENT_BITS] = wr_data;
      end
`endif
    end
  end

  // Output row register; a stall freezes it along with the sequencer.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
      r_err_oob  <= 1'b0;
    end else begin
      r_err_oob <= w_wr_oob || w_base_oob;
      if (!rd_stall) begin
        r_rd_valid <= w_rd_en;
        r_rd_last  <= w_rd_last;
        r_rd_data  <= w_rd_en ? w_row_data : '0;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign rd_data  = r_rd_data;
  assign err_oob  = r_err_oob;

endmodule
